rca_config_controller: RTL

- Sequences RCA configuration instructions against in-flight RCA use instructions.
- Holds the per-RCA source and destination register-address tables.
- Before rewriting an RCA's table, drains that RCA's in-flight uses, then acknowledges the config instruction by ID.
- Sits between issue and the RCA unit; supplies the register-address map for the RCA selected at issue.

---
 rtl/rca_config_controller_pkg.sv | 39 +++
 rtl/rca_config_controller_inflight_counter.sv | 46 ++++
 rtl/rca_config_controller.sv | 142 ++++++++++++++
 3 files changed

// File: rtl/rca_config_controller_pkg.sv
`default_nettype none
// ============================================================================
// Module   : rca_config_controller_pkg
// Purpose  : Shared constants and types for the RCA configuration controller.
// Revision : 1.0 - initial release
// ============================================================================
package rca_config_controller_pkg;

  localparam int C_NUM_RCAS        = 3;
  localparam int C_NUM_READ_PORTS  = 5;
  localparam int C_NUM_WRITE_PORTS = 2;
  localparam int C_MAX_INFLIGHT    = 4;
  localparam int C_MAX_IDS         = 8;
  localparam int C_REG_W           = 5;
  localparam int C_ID_W            = $clog2(C_MAX_IDS);
  localparam int C_RCA_W           = $clog2(C_NUM_RCAS);
  localparam int C_PORT_W          = $clog2(C_NUM_READ_PORTS);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRAIN = 2'd1,
    WRITE = 2'd2
  } rca_cfg_state_t;

  typedef struct packed {
    logic [C_ID_W-1:0]   id;
    logic [C_RCA_W-1:0]  rca_sel;
    logic [C_PORT_W-1:0] port_sel;
    logic                src_dest;
    logic [C_REG_W-1:0]  reg_addr;
  } rca_cfg_request_t;

  typedef struct packed {
    logic [C_NUM_READ_PORTS-1:0][C_REG_W-1:0]  src_reg_addrs;
    logic [C_NUM_WRITE_PORTS-1:0][C_REG_W-1:0] dest_reg_addrs;
  } rca_config_t;

endpackage
`default_nettype wire

// File: rtl/rca_config_controller_inflight_counter.sv
`default_nettype none
// ============================================================================
// Module   : rca_inflight_counter
// Purpose  : Saturating count of outstanding use instructions for one RCA.
// Revision : 1.0 - initial release
// ============================================================================
module rca_inflight_counter #(
  parameter int MAX_INFLIGHT = 4,
  localparam int CNT_W       = $clog2(MAX_INFLIGHT + 1)
) (
  input  logic clk,
  input  logic rst,
  input  logic inc,
  input  logic dec,
  output logic zero_next,
  output logic full
);

  localparam logic [CNT_W-1:0] C_MAX = CNT_W'(MAX_INFLIGHT);

  logic [CNT_W-1:0] r_count;
  logic [CNT_W-1:0] w_count_next;

  // Simultaneous inc/dec cancels; ends of the range absorb the excess request.
  always_comb begin
    w_count_next = r_count;
    if (inc && !dec && (r_count != C_MAX)) begin
      w_count_next = r_count + 1'b1;
    end else if (dec && !inc && (r_count != '0)) begin
      w_count_next = r_count - 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_count <= '0;
    end else begin
      r_count <= w_count_next;
    end
  end

  assign zero_next = (w_count_next == '0);
  assign full      = (r_count == C_MAX);

endmodule
`default_nettype wire

// File: rtl/rca_config_controller.sv
`default_nettype none
// ============================================================================
// Module   : rca_config_controller
// Purpose  : Drains an RCA's in-flight uses, rewrites its register map, acks.
// Revision : 1.0 - initial release
// ============================================================================
module rca_config_controller
  import rca_config_controller_pkg::*;
#(
  // Table and request types are sized from the package constants these mirror.
  parameter int NUM_RCAS        = C_NUM_RCAS,
  parameter int NUM_READ_PORTS  = C_NUM_READ_PORTS,
  parameter int NUM_WRITE_PORTS = C_NUM_WRITE_PORTS,
  parameter int MAX_INFLIGHT    = C_MAX_INFLIGHT,
  parameter int MAX_IDS         = C_MAX_IDS
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               cfg_valid,
  output logic                               cfg_ready,
  input  logic [$clog2(MAX_IDS)-1:0]         cfg_id,
  input  logic [$clog2(NUM_RCAS)-1:0]        cfg_rca_sel,
  input  logic [$clog2(NUM_READ_PORTS)-1:0]  cfg_w_port_sel,
  input  logic                               cfg_w_src_dest_port,
  input  logic [4:0]                         cfg_w_reg_addr,
  input  logic                               use_issue,
  input  logic [$clog2(NUM_RCAS)-1:0]        use_issue_rca_sel,
  input  logic                               use_complete,
  input  logic [$clog2(NUM_RCAS)-1:0]        use_complete_rca_sel,
  output logic [NUM_RCAS-1:0]                use_block,
  output logic                               cfg_done,
  output logic [$clog2(MAX_IDS)-1:0]         cfg_done_id,
  input  logic [$clog2(NUM_RCAS)-1:0]        rd_rca_sel,
  output logic [5*NUM_READ_PORTS-1:0]        rca_src_reg_addrs,
  output logic [5*NUM_WRITE_PORTS-1:0]       rca_dest_reg_addrs
);

  localparam int RCA_W  = $clog2(NUM_RCAS);
  localparam int PORT_W = $clog2(NUM_READ_PORTS);

  rca_cfg_state_t   r_state;
  rca_cfg_request_t r_req;
  rca_config_t      r_table [NUM_RCAS];

  logic [NUM_RCAS-1:0] w_zero_next;
  logic [NUM_RCAS-1:0] w_full;
  logic                w_tgt_zero;
  logic                w_held_zero;

  for (genvar i = 0; i < NUM_RCAS; i++) begin : g_rca
    rca_inflight_counter #(
      .MAX_INFLIGHT(MAX_INFLIGHT)
    ) u_cnt (
      .clk       (clk),
      .rst       (rst),
      .inc       (use_issue && (use_issue_rca_sel == RCA_W'(i))),
      .dec       (use_complete && (use_complete_rca_sel == RCA_W'(i))),
      .zero_next (w_zero_next[i]),
      .full      (w_full[i])
    );

    assign use_block[i] = ((r_state != IDLE) && (r_req.rca_sel == RCA_W'(i))) || w_full[i];
  end

  // Post-edge emptiness of the incoming and the held target RCA.
  always_comb begin
    w_tgt_zero  = 1'b1;
    w_held_zero = 1'b1;
    for (int i = 0; i < NUM_RCAS; i++) begin
      if (cfg_rca_sel == RCA_W'(i)) begin
        w_tgt_zero = w_zero_next[i];
      end
      if (r_req.rca_sel == RCA_W'(i)) begin
        w_held_zero = w_zero_next[i];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
      r_req   <= '0;
      for (int i = 0; i < NUM_RCAS; i++) begin
        r_table[i] <= '0;
      end
    end else begin
      case (r_state)
        IDLE: begin
          if (cfg_valid) begin
            r_req.id       <= cfg_id;
            r_req.rca_sel  <= cfg_rca_sel;
            r_req.port_sel <= cfg_w_port_sel;
            r_req.src_dest <= cfg_w_src_dest_port;
            r_req.reg_addr <= cfg_w_reg_addr;
            r_state        <= w_tgt_zero ? WRITE : DRAIN;
          end
        end
        DRAIN: begin
          if (w_held_zero) begin
            r_state <= WRITE;
          end
        end
        WRITE: begin
          // Out-of-range slot indices match no entry and leave the table alone.
          for (int i = 0; i < NUM_RCAS; i++) begin
            if (r_req.rca_sel == RCA_W'(i)) begin
              for (int k = 0; k < NUM_READ_PORTS; k++) begin
                if (!r_req.src_dest && (r_req.port_sel == PORT_W'(k))) begin
                  r_table[i].src_reg_addrs[k] <= r_req.reg_addr;
                end
              end
              for (int k = 0; k < NUM_WRITE_PORTS; k++) begin
                if (r_req.src_dest && (r_req.port_sel == PORT_W'(k))) begin
                  r_table[i].dest_reg_addrs[k] <= r_req.reg_addr;
                end
              end
            end
          end
          r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign cfg_ready   = (r_state == IDLE);
  assign cfg_done    = (r_state == WRITE);
  assign cfg_done_id = cfg_done ? r_req.id : '0;

  always_comb begin
    rca_src_reg_addrs  = '0;
    rca_dest_reg_addrs = '0;
    for (int i = 0; i < NUM_RCAS; i++) begin
      if (rd_rca_sel == RCA_W'(i)) begin
        rca_src_reg_addrs  = r_table[i].src_reg_addrs;
        rca_dest_reg_addrs = r_table[i].dest_reg_addrs;
      end
    end
  end

endmodule
`default_nettype wire
